vxe_vpu_cmd_dispatch_mfu: RTL and testbench
===========================================

# vxe_vpu_cmd_dispatch_mfu

Parametrised command dispatcher for the VPU. It takes commands from the command queue and routes each one to one of NR_FU functional units, selected by the command's opcode. It sits between vxe_vpu_cmd_queue and the execution control units. The number of units, the field widths and the concurrency mode are configurable. Unlike the fixed serial dispatcher, it supports several units in flight at once, a SYNC barrier and error reporting for unmapped opcodes.

## Interface
Parameters:
- NR_FU, 4 — number of functional units, 1..8.
- OP_W, 5 — opcode width.
- FU_IDX_W, 2 — width of the opcode field that selects the unit, op[OP_W-1 -: FU_IDX_W]; 2^FU_IDX_W >= NR_FU.
- TH_W, 3 — thread id width.
- PL_W, 48 — payload width.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- i_vld  in  1  queue head valid.
- o_rd  out  1  pop queue head; combinational.
- i_op  in  OP_W  head opcode.
- i_th  in  TH_W  head thread.
- i_pl  in  PL_W  head payload.
- i_clr_err  in  1  clears o_err.
- o_busy  out  1  a head is pending or any unit is in flight.
- o_err  out  1  sticky: an unmapped unit index was popped.
- o_fu_disp  out  NR_FU  one-cycle dispatch pulse per unit.
- i_fu_done  in  NR_FU  one-cycle completion pulse per unit.
- o_fu_cmd_op  out  OP_W  registered command bus, op.
- o_fu_cmd_th  out  TH_W  registered command bus, thread.
- o_fu_cmd_pl  out  PL_W  registered command bus, payload.
- o_fu_act  out  NR_FU  in-flight flags per unit; these drive register-file datapath mux ownership.

## Operation
- Opcode 0 is SYNC. Unit index k = op[OP_W-1 -: FU_IDX_W] for every other opcode.
- **SYNC:** popped only when o_fu_act == 0; never dispatched.
- **k >= NR_FU:** popped immediately, o_err set, nothing dispatched.
- **Dispatch condition for valid k:** i_vld and act[k] == 0 and the mode condition holds.
  - Concurrent mode: no further condition.
  - Serial mode: o_fu_act == 0 is also required.
- **When the dispatch condition holds in cycle t:**
  - o_rd = 1 in cycle t.
  - In cycle t+1: o_fu_disp[k] = 1, the command bus holds op/th/pl, act[k] = 1.
- The command bus holds its value until the next dispatch. Units must sample it on the disp pulse.
- Commands issue strictly in order. A blocked head stalls everything behind it; there is no bypass.
- i_fu_done[k] in cycle u clears act[k] in cycle u+1. A done pulse on an idle unit is ignored.
- A done pulse and a new decision for the same unit in the same cycle: the unit is still seen as busy, so no dispatch that cycle.
- o_err is set in the cycle after the bad pop. Set has priority over a simultaneous i_clr_err.
- o_busy = i_vld | (o_fu_act != 0).

## Timing
- Reset values: o_fu_disp = 0, o_fu_act = 0, command bus = 0, o_err = 0. o_rd is 0 during reset (gated by nrst).
- Reset mid-operation drops all in-flight flags immediately. Later done pulses are ignored.
- Dispatch latency: o_rd to o_fu_disp is 1 cycle.
- Minimum back-to-back issue to different units is one command per cycle (concurrent mode only).
- Same-unit reissue: done in cycle u, next disp no earlier than u+2.
- Serial mode: last done in cycle u, next disp no earlier than u+2.
- i_vld must come from a registered queue output, so there is no combinational loop through o_rd.

## Configuration
- VXE_VPU_DISP_CONCURRENT_EN
  - Defined: concurrent mode as above; multiple bits of o_fu_act may be set.
  - Undefined: serial mode; o_fu_act is at most one-hot and behaviour is cycle-identical to the legacy serial dispatcher.

## Structure
- Shared package vxe_vpu_pkg:
  - SYNC opcode constant.
  - FU index localparams (REGU, PROD, STOR, ACTF).
  - Default widths.
- Sub-module vxe_vpu_disp_fu_track: one instance per unit.
  - Holds the act flag.
  - Sets on disp, clears on done.
  - Exposes the idle flag.

## Test plan
- **Single command:** PROD op with k = 1, th = 3, pl = 0xABC.
  - o_rd in cycle t; o_fu_disp = 4'b0010 and the bus carries th = 3, pl = 0xABC in t+1.
  - i_fu_done[1] in cycle u; act[1] clears in u+1; o_busy falls once i_vld is also 0.
- **Concurrent issue:** commands to units 0, 1, 3 back-to-back with no done.
  - Three disp pulses on consecutive cycles; o_fu_act = 4'b1011.
  - With the macro undefined, the second command waits until done[0] is seen + 1 cycle.
- **Same-unit stall:** two commands to unit 2, done asserted 5 cycles after the first disp.
  - Second disp occurs exactly 2 cycles after done.
- **SYNC barrier:** act = 4'b0101, head = SYNC, next head for unit 1.
  - SYNC is held until both done pulses are seen.
  - It pops the cycle act reaches 0, and unit 1 is dispatched after that.
- **Unmapped opcode:** NR_FU = 3, command with k = 3.
  - Popped, o_err = 1, no disp.
  - i_clr_err clears o_err; o_err = 1 again if the clear and a new bad pop coincide.
- **Reset mid-flight:** o_fu_act = 4'b0110, then nrst asserted.
  - All outputs go to 0 immediately.
  - A stray i_fu_done after reset leaves act at 0.

Source files
------------

// File: rtl/vxe_vpu_pkg.sv
// Shared VPU definitions: SYNC opcode, functional-unit indices, default widths
// and the head-of-queue classification used by the dispatcher.
package vxe_vpu_pkg;

    localparam int NR_FU_DEF    = 4;
    localparam int OP_W_DEF     = 5;
    localparam int FU_IDX_W_DEF = 2;
    localparam int TH_W_DEF     = 3;
    localparam int PL_W_DEF     = 48;

    localparam int SYNC_OP = 0;

    localparam int FU_REGU = 0;
    localparam int FU_PROD = 1;
    localparam int FU_STOR = 2;
    localparam int FU_ACTF = 3;

    typedef enum logic [1:0] {
        HEAD_IDLE,
        HEAD_SYNC,
        HEAD_FU,
        HEAD_BAD
    } head_kind_e;

endpackage

// File: rtl/vxe_vpu_disp_fu_track.sv
// Per-unit in-flight tracker: set by a dispatch, cleared by the unit's done
// pulse. A done pulse on an idle unit has no effect.
module vxe_vpu_disp_fu_track (
    input  logic clk,
    input  logic nrst,
    input  logic set,
    input  logic done,
    output logic act,
    output logic idle
);

    logic act_reg;

    // A set can only arrive while idle, so it never competes with a real done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            act_reg <= 1'b0;
        end else if (set) begin
            act_reg <= 1'b1;
        end else if (done) begin
            act_reg <= 1'b0;
        end
    end

    assign act  = act_reg;
    assign idle = ~act_reg;

endmodule

// File: rtl/vxe_vpu_cmd_dispatch_mfu.sv
// In-order command dispatcher routing queue heads to NR_FU units by opcode field.
// Define VXE_VPU_DISP_CONCURRENT_EN to allow several units in flight at once.
module vxe_vpu_cmd_dispatch_mfu
    import vxe_vpu_pkg::*;
#(
    parameter int NR_FU    = NR_FU_DEF,
    parameter int OP_W     = OP_W_DEF,
    parameter int FU_IDX_W = FU_IDX_W_DEF,
    parameter int TH_W     = TH_W_DEF,
    parameter int PL_W     = PL_W_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_vld,
    output logic             o_rd,
    input  logic [OP_W-1:0]  i_op,
    input  logic [TH_W-1:0]  i_th,
    input  logic [PL_W-1:0]  i_pl,
    input  logic             i_clr_err,
    output logic             o_busy,
    output logic             o_err,
    output logic [NR_FU-1:0] o_fu_disp,
    input  logic [NR_FU-1:0] i_fu_done,
    output logic [OP_W-1:0]  o_fu_cmd_op,
    output logic [TH_W-1:0]  o_fu_cmd_th,
    output logic [PL_W-1:0]  o_fu_cmd_pl,
    output logic [NR_FU-1:0] o_fu_act
);

`ifdef VXE_VPU_DISP_CONCURRENT_EN
    localparam bit CONCURRENT = 1'b1;
`else
    localparam bit CONCURRENT = 1'b0;
`endif

    logic [FU_IDX_W-1:0] fu_idx;
    logic [NR_FU-1:0]    fu_sel;
    logic [NR_FU-1:0]    fu_idle;
    logic [NR_FU-1:0]    fu_act;
    logic [NR_FU-1:0]    disp_next;
    logic [NR_FU-1:0]    disp_reg;
    logic [OP_W-1:0]     op_reg;
    logic [TH_W-1:0]     th_reg;
    logic [PL_W-1:0]     pl_reg;
    logic                err_reg;
    logic                any_act;
    logic                unit_free;
    logic                mode_ok;
    logic                pop;
    logic                bad_pop;
    head_kind_e          head_kind;

    assign fu_idx = i_op[OP_W-1 -: FU_IDX_W];

    // fu_sel is all-zero when the index names no existing unit.
    generate
        for (genvar gi = 0; gi < NR_FU; gi++) begin : g_fu
            assign fu_sel[gi] = (fu_idx == FU_IDX_W'(gi));

            vxe_vpu_disp_fu_track u_track (
                .clk  (clk),
                .nrst (nrst),
                .set  (disp_next[gi]),
                .done (i_fu_done[gi]),
                .act  (fu_act[gi]),
                .idle (fu_idle[gi])
            );
        end
    endgenerate

    assign any_act   = |fu_act;
    assign unit_free = |(fu_sel & fu_idle);
    assign mode_ok   = CONCURRENT || !any_act;

    always_comb begin
        head_kind = HEAD_IDLE;
        if (i_vld) begin
            if (i_op == OP_W'(SYNC_OP)) begin
                head_kind = HEAD_SYNC;
            end else if (fu_sel == '0) begin
                head_kind = HEAD_BAD;
            end else begin
                head_kind = HEAD_FU;
            end
        end
    end

    // Busy test uses the registered flag, so a same-cycle done still blocks.
    always_comb begin
        pop       = 1'b0;
        bad_pop   = 1'b0;
        disp_next = '0;
        case (head_kind)
            HEAD_SYNC: pop = !any_act;
            HEAD_BAD: begin
                pop     = 1'b1;
                bad_pop = 1'b1;
            end
            HEAD_FU: begin
                if (unit_free && mode_ok) begin
                    pop       = 1'b1;
                    disp_next = fu_sel;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            disp_reg <= '0;
            op_reg   <= '0;
            th_reg   <= '0;
            pl_reg   <= '0;
            err_reg  <= 1'b0;
        end else begin
            disp_reg <= disp_next;
            if (disp_next != '0) begin
                op_reg <= i_op;
                th_reg <= i_th;
                pl_reg <= i_pl;
            end
            if (bad_pop) begin
                err_reg <= 1'b1;
            end else if (i_clr_err) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign o_rd        = nrst & pop;
    assign o_busy      = i_vld | any_act;
    assign o_err       = err_reg;
    assign o_fu_disp   = disp_reg;
    assign o_fu_cmd_op = op_reg;
    assign o_fu_cmd_th = th_reg;
    assign o_fu_cmd_pl = pl_reg;
    assign o_fu_act    = fu_act;

endmodule

// File: tb/tb_vxe_vpu_cmd_dispatch_mfu.sv
// Directed bench for the multi-unit dispatcher; expectations follow the build mode
// selected by VXE_VPU_DISP_CONCURRENT_EN.
module tb_vxe_vpu_cmd_dispatch_mfu;

    localparam logic [4:0] OP_SYNC = 5'b00000;
    localparam logic [4:0] OP_U0   = 5'b00001;
    localparam logic [4:0] OP_U1   = 5'b01001;
    localparam logic [4:0] OP_U2   = 5'b10001;
    localparam logic [4:0] OP_U3   = 5'b11001;

    logic        clk = 1'b0;
    logic        nrst;
    logic        vld;
    logic        rd;
    logic [4:0]  op;
    logic [2:0]  th;
    logic [47:0] pl;
    logic        clr_err;
    logic        busy;
    logic        err;
    logic [3:0]  disp;
    logic [3:0]  done;
    logic [4:0]  cmd_op;
    logic [2:0]  cmd_th;
    logic [47:0] cmd_pl;
    logic [3:0]  act;

    logic        b_vld;
    logic        b_rd;
    logic [4:0]  b_op;
    logic        b_clr;
    logic        b_busy;
    logic        b_err;
    logic [2:0]  b_disp;
    logic [2:0]  b_done;
    logic [4:0]  b_cmd_op;
    logic [2:0]  b_cmd_th;
    logic [47:0] b_cmd_pl;
    logic [2:0]  b_act;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vxe_vpu_cmd_dispatch_mfu dut (
        .clk(clk), .nrst(nrst), .i_vld(vld), .o_rd(rd), .i_op(op), .i_th(th),
        .i_pl(pl), .i_clr_err(clr_err), .o_busy(busy), .o_err(err),
        .o_fu_disp(disp), .i_fu_done(done), .o_fu_cmd_op(cmd_op),
        .o_fu_cmd_th(cmd_th), .o_fu_cmd_pl(cmd_pl), .o_fu_act(act)
    );

    vxe_vpu_cmd_dispatch_mfu #(.NR_FU(3)) dut_b (
        .clk(clk), .nrst(nrst), .i_vld(b_vld), .o_rd(b_rd), .i_op(b_op), .i_th(3'd5),
        .i_pl(48'h123), .i_clr_err(b_clr), .o_busy(b_busy), .o_err(b_err),
        .o_fu_disp(b_disp), .i_fu_done(b_done), .o_fu_cmd_op(b_cmd_op),
        .o_fu_cmd_th(b_cmd_th), .o_fu_cmd_pl(b_cmd_pl), .o_fu_act(b_act)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        vld  = 1'b0;
        done = 4'b1111;
        step();
        done = 4'b0000;
        chk(tag, 64'(act), 64'h0);
    endtask

    initial begin
        nrst = 1'b0; vld = 1'b1; op = OP_U1; th = '0; pl = '0; clr_err = 1'b0; done = '0;
        b_vld = 1'b0; b_op = '0; b_clr = 1'b0; b_done = '0;

        // Reset state
        repeat (2) step();
        #1;
        chk("rst_rd", 64'(rd), 64'h0);
        chk("rst_disp", 64'(disp), 64'h0);
        chk("rst_act", 64'(act), 64'h0);
        chk("rst_cmd_op", 64'(cmd_op), 64'h0);
        chk("rst_cmd_pl", 64'(cmd_pl), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        vld  = 1'b0;
        nrst = 1'b1;

        // Single command to unit 1
        $display("[TB] single command");
        step();
        vld = 1'b1; op = OP_U1; th = 3'd3; pl = 48'hABC;
        #1;
        chk("single_rd", 64'(rd), 64'h1);
        step();
        vld = 1'b0;
        chk("single_disp", 64'(disp), 64'h2);
        chk("single_th", 64'(cmd_th), 64'h3);
        chk("single_pl", 64'(cmd_pl), 64'hABC);
        chk("single_op", 64'(cmd_op), 64'(OP_U1));
        chk("single_act", 64'(act), 64'h2);
        #1;
        chk("single_busy", 64'(busy), 64'h1);
        step();
        chk("single_disp_pulse", 64'(disp), 64'h0);
        chk("single_pl_hold", 64'(cmd_pl), 64'hABC);
        done = 4'b0010;
        step();
        done = 4'b0000;
        chk("single_act_clr", 64'(act), 64'h0);
        #1;
        chk("single_busy_fall", 64'(busy), 64'h0);

        // Back-to-back commands to units 0, 1, 3
        $display("[TB] issue units 0,1,3");
        step();
        vld = 1'b1; op = OP_U0;
        #1;
        chk("b2b_rd0", 64'(rd), 64'h1);
        step();
        chk("b2b_disp0", 64'(disp), 64'h1);
        op = OP_U1;
`ifdef VXE_VPU_DISP_CONCURRENT_EN
        #1;
        chk("b2b_rd1", 64'(rd), 64'h1);
        step();
        chk("b2b_disp1", 64'(disp), 64'h2);
        op = OP_U3;
        #1;
        chk("b2b_rd3", 64'(rd), 64'h1);
        step();
        chk("b2b_disp3", 64'(disp), 64'h8);
        chk("b2b_act", 64'(act), 64'hB);
        drain("b2b_drain");
`else
        #1;
        chk("ser_rd1_blocked", 64'(rd), 64'h0);
        step();
        chk("ser_disp_idle", 64'(disp), 64'h0);
        done = 4'b0001;
        #1;
        chk("ser_rd1_same_done", 64'(rd), 64'h0);
        step();
        done = 4'b0000;
        chk("ser_act_clr", 64'(act), 64'h0);
        #1;
        chk("ser_rd1", 64'(rd), 64'h1);
        step();
        chk("ser_disp1", 64'(disp), 64'h2);
        op = OP_U3;
        #1;
        chk("ser_rd3_blocked", 64'(rd), 64'h0);
        drain("ser_drain");
`endif

        // Same-unit stall on unit 2
        $display("[TB] same-unit stall");
        step();
        vld = 1'b1; op = OP_U2; th = 3'd1;
        #1;
        chk("same_rd_first", 64'(rd), 64'h1);
        step();
        chk("same_disp_first", 64'(disp), 64'h4);
        th = 3'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("same_wait_rd", 64'(rd), 64'h0);
        end
        step();
        done = 4'b0100;
        #1;
        chk("same_done_cycle_rd", 64'(rd), 64'h0);
        step();
        done = 4'b0000;
        chk("same_u1_disp", 64'(disp), 64'h0);
        #1;
        chk("same_u1_rd", 64'(rd), 64'h1);
        step();
        chk("same_u2_disp", 64'(disp), 64'h4);
        chk("same_u2_th", 64'(cmd_th), 64'h2);
        drain("same_drain");

        // SYNC barrier
        $display("[TB] sync barrier");
        step();
        vld = 1'b1; op = OP_U0;
        #1;
        chk("sync_rd_u0", 64'(rd), 64'h1);
        step();
`ifdef VXE_VPU_DISP_CONCURRENT_EN
        op = OP_U2;
        #1;
        chk("sync_rd_u2", 64'(rd), 64'h1);
        step();
        op = OP_SYNC;
        chk("sync_act_5", 64'(act), 64'h5);
        #1;
        chk("sync_hold0", 64'(rd), 64'h0);
        step();
        done = 4'b0001;
        step();
        done = 4'b0000;
        chk("sync_act_4", 64'(act), 64'h4);
        #1;
        chk("sync_hold1", 64'(rd), 64'h0);
        step();
        done = 4'b0100;
        #1;
        chk("sync_hold2", 64'(rd), 64'h0);
`else
        op = OP_SYNC;
        #1;
        chk("sync_hold0", 64'(rd), 64'h0);
        step();
        done = 4'b0001;
        #1;
        chk("sync_hold2", 64'(rd), 64'h0);
`endif
        step();
        done = 4'b0000;
        chk("sync_act_0", 64'(act), 64'h0);
        #1;
        chk("sync_pop", 64'(rd), 64'h1);
        step();
        op = OP_U1;
        chk("sync_no_disp", 64'(disp), 64'h0);
        #1;
        chk("sync_next_rd", 64'(rd), 64'h1);
        step();
        chk("sync_next_disp", 64'(disp), 64'h2);
        drain("sync_drain");

        // Unmapped opcode on the three-unit instance
        $display("[TB] unmapped opcode");
        step();
        b_vld = 1'b1; b_op = OP_U3;
        #1;
        chk("bad_rd", 64'(b_rd), 64'h1);
        chk("bad_err_before", 64'(b_err), 64'h0);
        step();
        b_vld = 1'b0;
        chk("bad_err", 64'(b_err), 64'h1);
        chk("bad_no_disp", 64'(b_disp), 64'h0);
        chk("bad_act", 64'(b_act), 64'h0);
        step();
        chk("bad_err_sticky", 64'(b_err), 64'h1);
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        chk("bad_err_clr", 64'(b_err), 64'h0);
        b_vld = 1'b1; b_op = OP_U3; b_clr = 1'b1;
        #1;
        chk("bad_rd2", 64'(b_rd), 64'h1);
        step();
        b_vld = 1'b0; b_clr = 1'b0;
        chk("bad_set_over_clr", 64'(b_err), 64'h1);

        // Reset while units are in flight
        $display("[TB] reset mid-flight");
        step();
        vld = 1'b1; op = OP_U1;
        step();
`ifdef VXE_VPU_DISP_CONCURRENT_EN
        op = OP_U2;
        step();
        vld = 1'b0;
        chk("midrst_act_pre", 64'(act), 64'h6);
`else
        vld = 1'b0;
        chk("midrst_act_pre", 64'(act), 64'h2);
`endif
        vld  = 1'b1; op = OP_U3;
        nrst = 1'b0;
        #1;
        chk("midrst_act", 64'(act), 64'h0);
        chk("midrst_disp", 64'(disp), 64'h0);
        chk("midrst_cmd_op", 64'(cmd_op), 64'h0);
        chk("midrst_cmd_pl", 64'(cmd_pl), 64'h0);
        chk("midrst_rd", 64'(rd), 64'h0);
        chk("midrst_b_err", 64'(b_err), 64'h0);
        step();
        vld  = 1'b0;
        nrst = 1'b1;
        done = 4'b1111; b_done = 3'b111;
        step();
        done = 4'b0000; b_done = 3'b000;
        chk("midrst_stray_done", 64'(act), 64'h0);
        chk("midrst_b_stray_done", 64'(b_act), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
